// File: rtl/gas_pattern_detector.sv
// gas_pattern_detector
//   Serial gas-signature detector. Searches the qualified bit stream (din
//   sampled only when din_valid=1) for a PAT_LEN-bit signature, MSB first.
//   Raises a one-cycle registered `match` pulse and a sticky `dout` alarm that
//   is cleared by `clear`. OVERLAP selects overlapping (1) or restarting (0)
//   search.
//
//   Build option: define GAS_DET_CNT_EN to add the saturating CNT_W-bit
//   `match_cnt` port and counter. Without it the counter and port are absent.
//
//   Reset `arst` is asynchronous and active-high. All outputs are registered.

module gas_pattern_detector #(
    parameter int                 PAT_LEN = 9,
    parameter logic [PAT_LEN-1:0] PATTERN = 9'b101101101,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             din_valid,
    input  logic             din,
    input  logic             clear,
    output logic             match,
    output logic             dout
`ifdef GAS_DET_CNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt
`endif
);

    // Fill counter must hold the values 0..PAT_LEN inclusive.
    localparam int FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_LEN - 1);
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);

    // One-hot encoding leaves unused codes that must be recovered from.
    typedef enum logic [1:0] {
        FILL = 2'b01,
        RUN  = 2'b10
    } state_t;

    // Catch illegal parameterisations at elaboration time.
    generate
        if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_pat_len
            $error("gas_pattern_detector: PAT_LEN must be in 2..16");
        end
        if (CNT_W < 1 || CNT_W > 16) begin : g_bad_cnt_w
            $error("gas_pattern_detector: CNT_W must be in 1..16");
        end
    endgenerate

    logic [PAT_LEN-1:0] hist_reg;
    logic [FILL_W-1:0]  fill_reg;
    state_t             state_reg;
    logic               match_reg;
    logic               dout_reg;

    logic [PAT_LEN-1:0] nxt;
    logic               window_full;
    logic               hit;

    // Candidate window including the bit being presented this cycle.
    assign nxt = {hist_reg[PAT_LEN-2:0], din};

    // The current bit completes a full window when PAT_LEN-1 bits are
    // already held, so the match can be flagged on the same edge.
    assign window_full = (fill_reg >= FILL_LAST);
    assign hit         = din_valid && window_full && (nxt == PATTERN);

    // Window shift register, fill count, FILL/RUN state and match pulse.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            hist_reg  <= '0;
            fill_reg  <= '0;
            state_reg <= FILL;
            match_reg <= 1'b0;
        end else begin
            match_reg <= hit;
            case (state_reg)
                FILL, RUN: begin
                    if (din_valid) begin
                        hist_reg <= nxt;
                        if (hit && !OVERLAP) begin
                            // Restart so no bit of the matched window is reused.
                            fill_reg  <= '0;
                            state_reg <= FILL;
                        end else begin
                            if (fill_reg != FILL_MAX) begin
                                fill_reg <= fill_reg + FILL_ONE;
                            end
                            state_reg <= window_full ? RUN : FILL;
                        end
                    end
                end
                default: begin
                    fill_reg  <= '0;
                    state_reg <= FILL;
                end
            endcase
        end
    end

    // Sticky alarm: a hit sets it and takes priority over a coincident clear.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            dout_reg <= 1'b0;
        end else if (hit) begin
            dout_reg <= 1'b1;
        end else if (clear) begin
            dout_reg <= 1'b0;
        end
    end

    assign match = match_reg;
    assign dout  = dout_reg;

`ifdef GAS_DET_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_next;

    // Clear is applied first, then a hit increments on top of the result.
    always_comb begin
        cnt_base = clear ? '0 : cnt_reg;
        cnt_next = cnt_base;
        if (hit && !(&cnt_base)) begin
            cnt_next = cnt_base + CNT_ONE;
        end
    end

    // Saturating match counter register.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign match_cnt = cnt_reg;
`endif

endmodule

// File: tb/tb_gas_pattern_detector.sv
// Testbench for gas_pattern_detector. Two instances share the input stream:
// dut0 searches with overlap, dut1 restarts after each match. Both use a 2-bit
// counter so saturation is reachable. Expected values come from a model that
// keeps every accepted bit in a queue plus, per instance, the queue position
// where the current search window started.

module tb_gas_pattern_detector;

    localparam int               PLEN = 9;
    localparam logic [PLEN-1:0]  PAT  = 9'b101101101;
    localparam int               CMAX = 3;

    logic clk = 1'b0;
    logic arst = 1'b1;
    logic din_valid = 1'b0;
    logic din = 1'b0;
    logic clear = 1'b0;
    logic match0, dout0, match1, dout1;
    logic [1:0] cnt0, cnt1;

    int n_checks = 0;
    int n_errors = 0;
    int pulses0 = 0;
    int pulses1 = 0;

    // Reference model state
    bit stream[$];
    int restart_at[2];
    bit m_match[2];
    bit m_dout[2];
    int m_cnt[2];

    always #5 clk = ~clk;

    gas_pattern_detector #(.OVERLAP(1'b1), .CNT_W(2)) dut0 (
        .clk(clk), .arst(arst), .din_valid(din_valid), .din(din), .clear(clear),
        .match(match0), .dout(dout0)
`ifdef GAS_DET_CNT_EN
        , .match_cnt(cnt0)
`endif
    );

    gas_pattern_detector #(.OVERLAP(1'b0), .CNT_W(2)) dut1 (
        .clk(clk), .arst(arst), .din_valid(din_valid), .din(din), .clear(clear),
        .match(match1), .dout(dout1)
`ifdef GAS_DET_CNT_EN
        , .match_cnt(cnt1)
`endif
    );

`ifndef GAS_DET_CNT_EN
    assign cnt0 = 2'd0;
    assign cnt1 = 2'd0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Does the tail of the accepted-bit stream spell the signature?
    function automatic bit tail_is_pattern();
        int base;
        if (stream.size() < PLEN) return 1'b0;
        base = stream.size() - PLEN;
        for (int k = 0; k < PLEN; k++) begin
            if (stream[base + k] != PAT[PLEN-1-k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int id = 0; id < 2; id++) begin
            restart_at[id] = stream.size();
            m_match[id] = 1'b0;
            m_dout[id] = 1'b0;
            m_cnt[id] = 0;
        end
    endtask

    task automatic model_step(input bit v, input bit d, input bit c);
        bit hit;
        if (v) stream.push_back(d);
        for (int id = 0; id < 2; id++) begin
            hit = v && ((stream.size() - restart_at[id]) >= PLEN) && tail_is_pattern();
            m_match[id] = hit;
            if (c) begin
                m_dout[id] = 1'b0;
                m_cnt[id] = 0;
            end
            if (hit) begin
                m_dout[id] = 1'b1;
                if (m_cnt[id] < CMAX) m_cnt[id]++;
                if (id == 1) restart_at[id] = stream.size();
            end
        end
    endtask

    task automatic chk_outputs();
        chk("match0", match0, m_match[0]);
        chk("dout0", dout0, m_dout[0]);
        chk("match1", match1, m_match[1]);
        chk("dout1", dout1, m_dout[1]);
`ifdef GAS_DET_CNT_EN
        chk("cnt0", cnt0, m_cnt[0]);
        chk("cnt1", cnt1, m_cnt[1]);
`endif
    endtask

    // One clock cycle: drive on the falling edge, check 1 time unit after the rising edge.
    task automatic step(input bit v, input bit d, input bit c);
        @(negedge clk);
        din_valid = v;
        din = d;
        clear = c;
        model_step(v, d, c);
        @(posedge clk);
        #1;
        chk_outputs();
        if (match0) pulses0++;
        if (match1) pulses1++;
        $display("cyc v=%0d d=%0d clr=%0d | m0=%0d o0=%0d c0=%0d | m1=%0d o1=%0d c1=%0d",
                 v, d, c, match0, dout0, cnt0, match1, dout1, cnt1);
    endtask

    // Valid bits, MSB first.
    task automatic drive_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], 1'b0);
    endtask

    // Assert reset between clock edges; outputs must drop immediately.
    task automatic do_arst();
        @(posedge clk);
        #2;
        arst = 1'b1;
        din_valid = 1'b0;
        clear = 1'b0;
        model_reset();
        #1;
        chk_outputs();
        @(negedge clk);
        @(negedge clk);
        arst = 1'b0;
        pulses0 = 0;
        pulses1 = 0;
    endtask

    initial begin
        int ph;
        bit b, v, c;
        model_reset();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk_outputs();
        arst = 1'b0;

        // Fill: 8 bits, a 9th, then the completing 01
        drive_bits(32'b01101101, 8);
        chk("fill8_pulses", pulses0, 0);
        drive_bits(32'b1, 1);
        chk("fill9_pulses", pulses0, 0);
        drive_bits(32'b01, 2);
        chk("fill_pulses0", pulses0, 1);
        chk("fill_dout0", dout0, 1);

        // Overlap vs restart on 101101101101
        do_arst();
        drive_bits(32'b101101101101, 12);
        chk("ovl_pulses0", pulses0, 2);
        chk("ovl_pulses1", pulses1, 1);
`ifdef GAS_DET_CNT_EN
        chk("ovl_cnt0", cnt0, 2);
        chk("ovl_cnt1", cnt1, 1);
`endif

        // Valid gaps after bit 4, din toggled while invalid
        do_arst();
        drive_bits(32'b1011, 4);
        for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        drive_bits(32'b01101, 5);
        chk("gap_pulses0", pulses0, 1);

        // Sticky alarm, clear, and clear coincident with a hit
        for (int i = 0; i < 20; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        chk("sticky_dout0", dout0, 1);
        step(1'b0, 1'b0, 1'b1);
        chk("clear_dout0", dout0, 0);
        drive_bits(32'b10, 2);
        step(1'b1, 1'b1, 1'b1);
        chk("clrhit_dout0", dout0, 1);
`ifdef GAS_DET_CNT_EN
        chk("clrhit_cnt0", cnt0, 1);
`endif

        // Counter saturation on repeated 101
        do_arst();
        drive_bits(32'b101101101, 9);
        for (int i = 0; i < 4; i++) drive_bits(32'b101, 3);
        chk("sat_pulses0", pulses0, 5);
`ifdef GAS_DET_CNT_EN
        chk("sat_cnt0", cnt0, 3);
`endif

        // Async reset mid-window, then the old window's tail
        do_arst();
        drive_bits(32'b101101101, 9);
        drive_bits(32'b101101, 6);
        do_arst();
        drive_bits(32'b101, 3);
        chk("postrst_pulses0", pulses0, 0);
        chk("postrst_pulses1", pulses1, 0);

        // Randomised stream biased towards the repeating signature
        ph = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) do_arst();
            b = ((ph % 3) != 1);
            if ($urandom_range(0, 7) == 0) b = 1'($urandom_range(0, 1));
            v = ($urandom_range(0, 7) != 0);
            c = ($urandom_range(0, 31) == 0);
            if (v) ph++;
            step(v, b, c);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
